// File: rtl/sram_bank_1024_16_qdi_rsp_pkg.sv
// Shared types and 1of4 code helpers for the QDI SRAM bank responder.
// Digit rails are one-hot; neutral is all rails low.
package sram_qdi_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int SYNC_D = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WNEUT,
    S_RREQ,
    S_RACK,
    S_RNEUT
  } state_t;

  typedef struct packed {
    logic [1:0] val;
    logic       valid;
    logic       illegal;
  } dig_t;

  function automatic logic [3:0] bin2onehot4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  function automatic dig_t onehot4_dec(input logic [3:0] r);
    dig_t       d;
    logic [2:0] n;
    n = 3'(r[0]) + 3'(r[1]) + 3'(r[2]) + 3'(r[3]);
    d.val     = {r[3] | r[2], r[3] | r[1]};
    d.valid   = (n == 3'd1);
    d.illegal = (n > 3'd1);
    return d;
  endfunction

endpackage

// File: rtl/sram_bank_1024_16_qdi_rsp_if.sv
// QDI SRAM bank port: RW, A, WriteData, ReadData channels with enables.
// master = initiator side, slave = bank responder side.
interface sram_bank_1024_16_qdi_rsp_if
  import sram_qdi_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic [2*AW-1:0] A;
  logic [AW/2-1:0] Ae;
  logic [1:0]      RW;
  logic            RWe;
  logic [2*DW-1:0] WriteData;
  logic [DW/2-1:0] WriteDataEn;
  logic [2*DW-1:0] ReadData;
  logic [DW/2-1:0] ReadDataEn;
  logic            ProtoErr;

  modport master (
    output A, RW, WriteData, ReadDataEn,
    input  Ae, RWe, WriteDataEn, ReadData, ProtoErr
  );

  modport slave (
    input  A, RW, WriteData, ReadDataEn,
    output Ae, RWe, WriteDataEn, ReadData, ProtoErr
  );
endinterface

// File: rtl/sram_bank_1024_16_qdi_rsp_sync.sv
// Multi-flop synchroniser for asynchronous rails.
// Clears to all-low (neutral) on reset.
module qdi_sync #(
  parameter int W = 1,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stg [D];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < D; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < D; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[D-1];
endmodule

// File: rtl/sram_bank_1024_16_qdi_rsp.sv
// Clocked responder for the QDI SRAM bank port backed by a word store.
// Decodes synced 1of4 requests and runs the four-phase handshakes.
module sram_bank_1024_16_qdi_rsp
  import sram_qdi_pkg::*;
#(
  parameter int AW   = ADDR_W,
  parameter int DW   = DATA_W,
  parameter int SYNC = SYNC_D
) (
  input logic CLK,
  input logic RESET,
  sram_bank_1024_16_qdi_rsp_if.slave bus
);
  localparam int NA = AW / 2;
  localparam int ND = DW / 2;

  logic [2*AW-1:0] aS;
  logic [1:0]      rwS;
  logic [2*DW-1:0] wdS;
  logic [ND-1:0]   reS;

  qdi_sync #(.W(2*AW), .D(SYNC)) uSyncA (
    .clk(CLK), .rstN(RESET), .d(bus.A), .q(aS)
  );
  qdi_sync #(.W(2), .D(SYNC)) uSyncRw (
    .clk(CLK), .rstN(RESET), .d(bus.RW), .q(rwS)
  );
  qdi_sync #(.W(2*DW), .D(SYNC)) uSyncWd (
    .clk(CLK), .rstN(RESET), .d(bus.WriteData), .q(wdS)
  );
  qdi_sync #(.W(ND), .D(SYNC)) uSyncRe (
    .clk(CLK), .rstN(RESET), .d(bus.ReadDataEn), .q(reS)
  );

  dig_t aDig [NA];
  dig_t wDig [ND];

  for (genvar i = 0; i < NA; i++) begin : gADec
    assign aDig[i] = onehot4_dec(aS[4*i +: 4]);
  end
  for (genvar i = 0; i < ND; i++) begin : gWDec
    assign wDig[i] = onehot4_dec(wdS[4*i +: 4]);
  end

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic aValid, aNeutral, wdValid, wdNeutral, anyIll;

  always_comb begin
    addr      = '0;
    wdata     = '0;
    aValid    = 1'b1;
    aNeutral  = 1'b1;
    wdValid   = 1'b1;
    wdNeutral = 1'b1;
    anyIll    = &rwS;
    for (int i = 0; i < NA; i++) begin
      addr[2*i +: 2] = aDig[i].val;
      aValid   = aValid & aDig[i].valid;
      aNeutral = aNeutral & ~(aDig[i].valid | aDig[i].illegal);
      anyIll   = anyIll | aDig[i].illegal;
    end
    for (int i = 0; i < ND; i++) begin
      wdata[2*i +: 2] = wDig[i].val;
      wdValid   = wdValid & wDig[i].valid;
      wdNeutral = wdNeutral & ~(wDig[i].valid | wDig[i].illegal);
      anyIll    = anyIll | wDig[i].illegal;
    end
  end

  logic rwValid, rwNeutral, reqOk, reqPrev, go, memWe;

  assign rwValid   = ^rwS;
  assign rwNeutral = ~|rwS;
  assign reqOk     = rwValid & aValid & (rwS[1] | wdValid);

  state_t          state;
  logic [NA-1:0]   aeQ;
  logic            rweQ;
  logic [ND-1:0]   wdeQ;
  logic [2*DW-1:0] rdQ;
  logic            perrQ;
  logic [DW-1:0]   rdata;
  logic [(1<<AW)-1:0] validV;
  logic [DW-1:0]   mem [1<<AW];

  // two consecutive valid samples filter out requests that collapse early
  assign go    = (state == S_IDLE) & reqOk & reqPrev;
  assign memWe = go & rwS[0];

  always_ff @(posedge CLK) begin
    if (memWe) mem[addr] <= wdata;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      aeQ     <= '1;
      rweQ    <= 1'b1;
      wdeQ    <= '1;
      rdQ     <= '0;
      perrQ   <= 1'b0;
      reqPrev <= 1'b0;
      rdata   <= '0;
      validV  <= '0;
    end else begin
      perrQ   <= perrQ | anyIll;
      reqPrev <= reqOk;
      unique case (state)
        S_IDLE: begin
          if (go && rwS[0]) begin
            validV[addr] <= 1'b1;
            aeQ          <= '0;
            rweQ         <= 1'b0;
            wdeQ         <= '0;
            state        <= S_WNEUT;
          end else if (go) begin
            rdata <= validV[addr] ? mem[addr] : '0;
            state <= S_RREQ;
          end
        end
        S_WNEUT: begin
          if (aNeutral && rwNeutral && wdNeutral) begin
            aeQ   <= '1;
            rweQ  <= 1'b1;
            wdeQ  <= '1;
            state <= S_IDLE;
          end
        end
        S_RREQ: begin
          if (&reS) begin
            for (int i = 0; i < ND; i++)
              rdQ[4*i +: 4] <= bin2onehot4(rdata[2*i +: 2]);
            aeQ   <= '0;
            rweQ  <= 1'b0;
            state <= S_RACK;
          end
        end
        S_RACK: begin
          if (~|reS) begin
            rdQ   <= '0;
            state <= S_RNEUT;
          end
        end
        S_RNEUT: begin
          if (aNeutral && rwNeutral) begin
            aeQ   <= '1;
            rweQ  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Ae          = aeQ;
  assign bus.RWe         = rweQ;
  assign bus.WriteDataEn = wdeQ;
  assign bus.ReadData    = rdQ;
  assign bus.ProtoErr    = perrQ;
endmodule

// File: tb/tb_sram_bank_1024_16_qdi_rsp.sv
// Directed bench for the QDI SRAM bank responder.
// Read results are checked against a scoreboard queue.
module tb_sram_bank_1024_16_qdi_rsp;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int nAssert = 0;
  int nFail = 0;

  logic [15:0] model [int];
  logic [15:0] expQ [$];

  sram_bank_1024_16_qdi_rsp_if bus ();

  sram_bank_1024_16_qdi_rsp dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rails16(input logic [15:0] v);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'b0001 << v[2*i +: 2];
    return r;
  endfunction

  function automatic logic [19:0] rails10(input logic [9:0] v);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'b0001 << v[2*i +: 2];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic neutral();
    bus.A = '0;
    bus.RW = '0;
    bus.WriteData = '0;
  endtask

  task automatic doWrite(input logic [9:0] a, input logic [15:0] d);
    int n;
    bus.A = rails10(a);
    bus.WriteData = rails16(d);
    bus.RW = 2'b01;
    for (n = 0; n < 100 && bus.WriteDataEn != '0; n++) tick(1);
    check("wr_en_fall", {bus.Ae, bus.RWe, bus.WriteDataEn}, 0);
    model[int'(a)] = d;
    neutral();
    for (n = 0; n < 100 && bus.Ae != '1; n++) tick(1);
    check("wr_en_rise", {bus.Ae, bus.RWe, bus.WriteDataEn}, 32'h3FFF);
  endtask

  task automatic doRead(input logic [9:0] a, input int hold);
    int n;
    logic [15:0] e;
    expQ.push_back(model.exists(int'(a)) ? model[int'(a)] : 16'h0000);
    bus.ReadDataEn = (hold > 0) ? 8'h00 : 8'hFF;
    bus.A = rails10(a);
    bus.RW = 2'b10;
    if (hold > 0) begin
      tick(hold);
      check("rd_hold_data", bus.ReadData, 0);
      check("rd_hold_en", {bus.Ae, bus.RWe}, 32'h3F);
      bus.ReadDataEn = 8'hFF;
    end
    for (n = 0; n < 100 && bus.ReadData == '0; n++) tick(1);
    e = expQ.pop_front();
    check("rd_data", bus.ReadData, rails16(e));
    check("rd_en_fall", {bus.Ae, bus.RWe}, 0);
    check("rd_wde_high", bus.WriteDataEn, 32'hFF);
    bus.ReadDataEn = 8'h00;
    for (n = 0; n < 100 && bus.ReadData != '0; n++) tick(1);
    check("rd_clear", bus.ReadData, 0);
    neutral();
    for (n = 0; n < 100 && bus.Ae != '1; n++) tick(1);
    check("rd_en_rise", {bus.Ae, bus.RWe}, 32'h3F);
  endtask

  initial begin
    int n;
    neutral();
    bus.ReadDataEn = 8'h00;
    tick(3);
    check("rst_ae", bus.Ae, 32'h1F);
    check("rst_rwe", bus.RWe, 1);
    check("rst_wde", bus.WriteDataEn, 32'hFF);
    check("rst_rdata", bus.ReadData, 0);
    check("rst_perr", bus.ProtoErr, 0);
    RESET = 1'b1;
    tick(2);

    doRead(10'h000, 0);
    doWrite(10'h000, 16'hFFFF);
    doRead(10'h000, 0);
    check("perr_clean", bus.ProtoErr, 0);

    doWrite(10'h3FF, 16'hA5C3);
    doWrite(10'h001, 16'h1234);
    doRead(10'h3FF, 0);
    doRead(10'h001, 0);
    doRead(10'h000, 50);

    // illegal address digit on a write: flagged, no handshake, no store update
    bus.A = rails10(10'h001);
    bus.A[11:8] = 4'b0101;
    bus.WriteData = rails16(16'h0BAD);
    bus.RW = 2'b01;
    tick(20);
    check("ill_perr", bus.ProtoErr, 1);
    check("ill_en", {bus.Ae, bus.RWe, bus.WriteDataEn}, 32'h3FFF);
    neutral();
    tick(6);
    doRead(10'h001, 0);

    // reset while the read data is being presented
    expQ.push_back(model[int'(10'h3FF)]);
    bus.ReadDataEn = 8'hFF;
    bus.A = rails10(10'h3FF);
    bus.RW = 2'b10;
    for (n = 0; n < 100 && bus.ReadData == '0; n++) tick(1);
    check("rack_data", bus.ReadData, rails16(expQ.pop_front()));
    RESET = 1'b0;
    #1;
    check("arst_rdata", bus.ReadData, 0);
    check("arst_en", {bus.Ae, bus.RWe, bus.WriteDataEn}, 32'h3FFF);
    check("arst_perr", bus.ProtoErr, 0);
    neutral();
    bus.ReadDataEn = 8'h00;
    tick(2);
    RESET = 1'b1;
    model.delete();
    tick(2);
    doRead(10'h3FF, 0);

    bus.A = rails10(10'h005);
    bus.RW = 2'b11;
    tick(20);
    check("rw11_perr", bus.ProtoErr, 1);
    check("rw11_en", {bus.Ae, bus.RWe, bus.WriteDataEn}, 32'h3FFF);
    neutral();
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end
endmodule
